dcache_dm: RTL and testbench

DCACHE_DM -- requirements
Module: dcache_dm

---
 rtl/dcache_dm.sv | 222 ++++++++++++++++++++++
 tb/tb_dcache_dm.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_dm.sv
`default_nettype none
// ============================================================================
// Module   : dcache_dm
// Brief    : Direct-mapped, write-through, no-write-allocate data cache.
//            Loads that hit return data one cycle after acceptance.
//            Loads that miss fetch a full line from memory.
//            Stores always go to memory. A store that hits also merges
//            its enabled bytes into the cached word.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_dm #(
  parameter int NUM_LINES = 16,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst,

  // Core side
  input  logic                 core_req,
  input  logic                 core_we,
  input  logic [31:0]          core_addr,
  input  logic [31:0]          core_wdata,
  input  logic [3:0]           core_be,
  output logic                 core_ready,
  output logic                 core_rvalid,
  output logic [31:0]          core_rdata,
  input  logic                 flush,

  // Memory line-read side
  output logic                 mem_rd_en,
  output logic [31:0]          mem_rd_addr,
  input  logic [LINE_BITS-1:0] mem_rd_data,
  input  logic                 mem_rd_valid,

  // Memory write-through side
  output logic                 mem_wr_en,
  output logic [31:0]          mem_wr_addr,
  output logic [31:0]          mem_wr_data,
  output logic [3:0]           mem_wr_be,
  input  logic                 mem_wr_ready
);

  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int TAG_LSB = 4 + IDX_W;
  localparam int TAG_W   = 32 - TAG_LSB;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_REFILL_REQ  = 3'd1,
    S_REFILL_WAIT = 3'd2,
    S_RESP        = 3'd3,
    S_WRITE       = 3'd4
  } state_e;

  state_e               state_q;

  // Line storage: valid bits are reset, tag and data arrays are not
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  // Word address of the outstanding load miss
  logic [31:2]          req_addr_q;

  // Registered outputs
  logic                 core_rvalid_q;
  logic [31:0]          core_rdata_q;
  logic                 mem_rd_en_q;
  logic [31:0]          mem_rd_addr_q;
  logic                 mem_wr_en_q;
  logic [31:0]          mem_wr_addr_q;
  logic [31:0]          mem_wr_data_q;
  logic [3:0]           mem_wr_be_q;

  // Decode of the incoming core address
  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic [1:0]           w_off;
  logic                 w_hit;
  logic [LINE_BITS-1:0] w_line;
  logic [31:0]          w_hit_word;
  logic [31:0]          w_store_word;

  // Decode of the latched miss address
  logic [IDX_W-1:0]     w_fill_idx;
  logic [TAG_W-1:0]     w_fill_tag;
  logic [1:0]           w_fill_off;
  logic [31:0]          w_fill_word;

  logic                 w_accept;
  logic                 w_refill_we;
  logic                 w_store_we;

  // Byte-offset bits of the core address carry no information for word accesses
  logic                 w_unused_addr;
  assign w_unused_addr = &{1'b0, core_addr[1:0]};

  assign w_idx      = core_addr[TAG_LSB-1:4];
  assign w_tag      = core_addr[31:TAG_LSB];
  assign w_off      = core_addr[3:2];
  assign w_line     = data_q[w_idx];
  assign w_hit      = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
  assign w_hit_word = w_line[{w_off, 5'b0} +: 32];

  assign w_fill_idx  = req_addr_q[TAG_LSB-1:4];
  assign w_fill_tag  = req_addr_q[31:TAG_LSB];
  assign w_fill_off  = req_addr_q[3:2];
  assign w_fill_word = mem_rd_data[{w_fill_off, 5'b0} +: 32];

  // The core may only hand over a request in IDLE. A flush has priority over a request.
  assign core_ready  = rst && (state_q == S_IDLE) && !flush;
  assign w_accept    = core_req && core_ready;
  assign w_refill_we = rst && (state_q == S_REFILL_WAIT) && mem_rd_valid;
  assign w_store_we  = w_accept && core_we && w_hit;

  // Merge the enabled store bytes into the currently cached word
  always_comb begin
    w_store_word = w_hit_word;
    for (int b = 0; b < 4; b++) begin
      if (core_be[b]) begin
        w_store_word[8*b +: 8] = core_wdata[8*b +: 8];
      end
    end
  end

  // Tag/data array writes: refill replaces the whole line, a store hit updates one word
  always_ff @(posedge clk) begin
    if (w_refill_we) begin
      data_q[w_fill_idx] <= mem_rd_data;
      tag_q[w_fill_idx]  <= w_fill_tag;
    end else if (w_store_we) begin
      data_q[w_idx][{w_off, 5'b0} +: 32] <= w_store_word;
    end
  end

  // Controller FSM with valid bits and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      req_addr_q    <= '0;
      core_rvalid_q <= 1'b0;
      core_rdata_q  <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      mem_wr_be_q   <= '0;
    end else begin
      // Single-cycle strobes fall back to zero unless re-armed below
      core_rvalid_q <= 1'b0;
      mem_rd_en_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (core_req) begin
            if (core_we) begin
              // Write-through. A hit also updates the array through w_store_we.
              mem_wr_en_q   <= 1'b1;
              mem_wr_addr_q <= {core_addr[31:2], 2'b00};
              mem_wr_data_q <= core_wdata;
              mem_wr_be_q   <= core_be;
              state_q       <= S_WRITE;
            end else if (w_hit) begin
              core_rvalid_q <= 1'b1;
              core_rdata_q  <= w_hit_word;
            end else begin
              req_addr_q    <= core_addr[31:2];
              mem_rd_en_q   <= 1'b1;
              mem_rd_addr_q <= {core_addr[31:4], 4'b0000};
              state_q       <= S_REFILL_REQ;
            end
          end
        end

        S_REFILL_REQ: begin
          // mem_rd_en was raised on entry and drops by default here
          state_q <= S_REFILL_WAIT;
        end

        S_REFILL_WAIT: begin
          if (mem_rd_valid) begin
            valid_q[w_fill_idx] <= 1'b1;
            core_rvalid_q       <= 1'b1;
            core_rdata_q        <= w_fill_word;
            state_q             <= S_RESP;
          end
        end

        S_RESP: begin
          state_q <= S_IDLE;
        end

        S_WRITE: begin
          if (mem_wr_ready) begin
            mem_wr_en_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          mem_wr_en_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign core_rvalid = core_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_wr_be   = mem_wr_be_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_dm.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_dm
// Brief    : Self-checking bench for dcache_dm.
//            Directed scenarios are followed by a randomized sequence.
//            Expected results come from a memory map and a model of which
//            line address each index currently holds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_dm;

  localparam int NUM_LINES = 16;
  localparam int LINE_BITS = 128;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 core_req = 1'b0;
  logic                 core_we = 1'b0;
  logic [31:0]          core_addr = '0;
  logic [31:0]          core_wdata = '0;
  logic [3:0]           core_be = '0;
  logic                 core_ready;
  logic                 core_rvalid;
  logic [31:0]          core_rdata;
  logic                 flush = 1'b0;
  logic                 mem_rd_en;
  logic [31:0]          mem_rd_addr;
  logic [LINE_BITS-1:0] mem_rd_data = '0;
  logic                 mem_rd_valid = 1'b0;
  logic                 mem_wr_en;
  logic [31:0]          mem_wr_addr;
  logic [31:0]          mem_wr_data;
  logic [3:0]           mem_wr_be;
  logic                 mem_wr_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  dcache_dm #(
    .NUM_LINES(NUM_LINES),
    .LINE_BITS(LINE_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_be     (core_be),
    .core_ready  (core_ready),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .flush       (flush),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_rd_valid(mem_rd_valid),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_be   (mem_wr_be),
    .mem_wr_ready(mem_wr_ready)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit [127:0] mem_m [bit [31:0]];        // backing memory, keyed by line address
  bit         mdl_valid [NUM_LINES];
  bit [31:0]  mdl_line  [NUM_LINES];     // line address held by each index

  function automatic bit [127:0] get_line(bit [31:0] la);
    bit [127:0] l;
    if (mem_m.exists(la)) return mem_m[la];
    for (int k = 0; k < 4; k++)
      l[k*32 +: 32] = (la * 32'h9E37_79B1) ^ (32'h0101_0101 * (k + 1));
    return l;
  endfunction

  function automatic bit [31:0] exp_word(bit [31:0] a);
    bit [127:0] l;
    l = get_line({a[31:4], 4'b0});
    return l[a[3:2]*32 +: 32];
  endfunction

  function automatic int mdl_idx(bit [31:0] a);
    return int'((a >> 4) % NUM_LINES);
  endfunction

  function automatic bit mdl_hit(bit [31:0] a);
    return mdl_valid[mdl_idx(a)] && (mdl_line[mdl_idx(a)] == {a[31:4], 4'b0});
  endfunction

  function automatic void mdl_fill(bit [31:0] a);
    mdl_valid[mdl_idx(a)] = 1'b1;
    mdl_line[mdl_idx(a)]  = {a[31:4], 4'b0};
  endfunction

  function automatic void mdl_clear();
    for (int i = 0; i < NUM_LINES; i++) mdl_valid[i] = 1'b0;
  endfunction

  function automatic void mdl_store(bit [31:0] a, bit [31:0] d, bit [3:0] be);
    bit [127:0] l;
    int w;
    l = get_line({a[31:4], 4'b0});
    w = int'(a[3:2]);
    for (int b = 0; b < 4; b++)
      if (be[b]) l[w*32 + b*8 +: 8] = d[b*8 +: 8];
    mem_m[{a[31:4], 4'b0}] = l;
  endfunction

  // ---------------- transaction drivers (no checking) ----------------
  task automatic do_load(input logic [31:0] a, input int dly, input bit flush_wait,
                         output int rd_cnt, output logic [31:0] rd_addr,
                         output logic [31:0] rdata, output int lat, output bit ok);
    int cd;
    bit done;
    rd_cnt = 0; rd_addr = '0; rdata = '0; lat = -1; ok = 1'b0; cd = -1; done = 1'b0;
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = a;
    #1;
    for (int w = 0; w < 20 && !core_ready; w++) begin @(negedge clk); #1; end
    if (!core_ready) begin core_req = 1'b0; return; end
    @(negedge clk);
    core_req = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      mem_rd_valid = 1'b0;
      if (core_rvalid) begin
        rdata = core_rdata; lat = c; done = 1'b1;
      end else if (mem_rd_en) begin
        rd_cnt++; rd_addr = mem_rd_addr; cd = dly;
        if (flush_wait) flush = 1'b1;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = get_line({rd_addr[31:4], 4'b0});
          flush        = 1'b0;
        end
      end
      if (!done) @(negedge clk);
    end
    ok = done; flush = 1'b0; mem_rd_valid = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input int rdy_dly, output int wr_cycles, output logic [31:0] wa,
                          output logic [31:0] wd, output logic [3:0] wbe, output bit ok);
    bit done;
    wr_cycles = 0; wa = '0; wd = '0; wbe = '0; ok = 1'b0; done = 1'b0;
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b1; core_addr = a; core_wdata = d; core_be = be;
    #1;
    for (int w = 0; w < 20 && !core_ready; w++) begin @(negedge clk); #1; end
    if (!core_ready) begin core_req = 1'b0; core_we = 1'b0; return; end
    @(negedge clk);
    core_req = 1'b0; core_we = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (mem_wr_en) begin
        wr_cycles++; wa = mem_wr_addr; wd = mem_wr_data; wbe = mem_wr_be;
        mem_wr_ready = (wr_cycles > rdy_dly);
      end else begin
        mem_wr_ready = 1'b0;
        if (wr_cycles > 0) done = 1'b1;
      end
      if (!done) @(negedge clk);
    end
    ok = done; mem_wr_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; core_req = 1'b1; core_addr = 32'h104;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (core_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready got=%b exp=0", core_ready); end
    n_checks++;
    if ({core_rvalid, mem_rd_en, mem_wr_en} !== 3'b000) begin
      n_errors++; $display("FAIL reset_strobes got=%b exp=000", {core_rvalid, mem_rd_en, mem_wr_en});
    end
    n_checks++;
    if ({core_rdata, mem_rd_addr, mem_wr_addr} !== 96'h0) begin
      n_errors++; $display("FAIL reset_data_addr rdata=%h rd_addr=%h wr_addr=%h exp=0", core_rdata, mem_rd_addr, mem_wr_addr);
    end
    core_req = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (core_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_ready got=%b exp=1", core_ready); end
    mdl_clear();
  endtask

  task automatic test_load_miss_hit();
    int rc, lat; logic [31:0] ra, rd; bit ok;
    mem_m[32'h100] = {32'h44, 32'h33, 32'h22, 32'h11};
    do_load(32'h104, 3, 1'b0, rc, ra, rd, lat, ok);
    n_checks++; if (!ok || rc != 1) begin n_errors++; $display("FAIL miss_rd_en ok=%0d rd_en_count=%0d exp=1", ok, rc); end
    n_checks++; if (ra !== 32'h100) begin n_errors++; $display("FAIL miss_rd_addr got=%h exp=00000100", ra); end
    n_checks++; if (rd !== 32'h22) begin n_errors++; $display("FAIL miss_rdata got=%h exp=00000022", rd); end
    mdl_fill(32'h104);
    do_load(32'h104, 3, 1'b0, rc, ra, rd, lat, ok);
    n_checks++; if (!ok || rc != 0 || lat != 0) begin n_errors++; $display("FAIL hit_latency ok=%0d rd_en=%0d lat=%0d exp rd_en=0 lat=0", ok, rc, lat); end
    n_checks++; if (rd !== 32'h22) begin n_errors++; $display("FAIL hit_rdata got=%h exp=00000022", rd); end
  endtask

  task automatic test_store_partial();
    int wc, rc, lat; logic [31:0] wa, wd, ra, rd; logic [3:0] wbe; bit ok;
    do_store(32'h104, 32'hAABB_CCDD, 4'b0011, 2, wc, wa, wd, wbe, ok);
    n_checks++; if (!ok || wc != 3) begin n_errors++; $display("FAIL store_wr_en_cycles ok=%0d got=%0d exp=3", ok, wc); end
    n_checks++;
    if ({wa, wd, wbe} !== {32'h104, 32'hAABB_CCDD, 4'b0011}) begin
      n_errors++; $display("FAIL store_fields addr=%h data=%h be=%b exp 00000104 aabbccdd 0011", wa, wd, wbe);
    end
    mdl_store(32'h104, 32'hAABB_CCDD, 4'b0011);
    do_load(32'h104, 3, 1'b0, rc, ra, rd, lat, ok);
    n_checks++; if (!ok || rc != 0) begin n_errors++; $display("FAIL store_hit_load_miss ok=%0d rd_en=%0d exp=0", ok, rc); end
    n_checks++; if (rd !== 32'h0000_CCDD) begin n_errors++; $display("FAIL store_merge got=%h exp=0000ccdd", rd); end
  endtask

  task automatic test_conflict();
    int rc, lat; logic [31:0] ra, rd; bit ok;
    do_load(32'h1104, 2, 1'b0, rc, ra, rd, lat, ok);
    n_checks++; if (!ok || rc != 1 || ra !== 32'h1100) begin n_errors++; $display("FAIL conflict_refill ok=%0d rd_en=%0d addr=%h exp 1 00001100", ok, rc, ra); end
    n_checks++; if (rd !== exp_word(32'h1104)) begin n_errors++; $display("FAIL conflict_rdata got=%h exp=%h", rd, exp_word(32'h1104)); end
    mdl_fill(32'h1104);
    do_load(32'h104, 1, 1'b0, rc, ra, rd, lat, ok);
    n_checks++; if (!ok || rc != 1 || ra !== 32'h100) begin n_errors++; $display("FAIL conflict_evict ok=%0d rd_en=%0d addr=%h exp 1 00000100", ok, rc, ra); end
    n_checks++; if (rd !== 32'h0000_CCDD) begin n_errors++; $display("FAIL conflict_reload got=%h exp=0000ccdd", rd); end
    mdl_fill(32'h104);
  endtask

  task automatic test_store_miss();
    int wc, rc, lat; logic [31:0] wa, wd, ra, rd; logic [3:0] wbe; bit ok;
    do_store(32'h200, 32'h1234_5678, 4'b0101, 1, wc, wa, wd, wbe, ok);
    n_checks++; if (!ok || wc != 2) begin n_errors++; $display("FAIL store_miss_cycles ok=%0d got=%0d exp=2", ok, wc); end
    n_checks++; if (wa !== 32'h200 || wbe !== 4'b0101) begin n_errors++; $display("FAIL store_miss_fields addr=%h be=%b exp 00000200 0101", wa, wbe); end
    mdl_store(32'h200, 32'h1234_5678, 4'b0101);
    do_load(32'h200, 2, 1'b0, rc, ra, rd, lat, ok);
    n_checks++; if (!ok || rc != 1) begin n_errors++; $display("FAIL store_no_allocate ok=%0d rd_en=%0d exp=1", ok, rc); end
    n_checks++; if (rd !== exp_word(32'h200)) begin n_errors++; $display("FAIL store_miss_rdata got=%h exp=%h", rd, exp_word(32'h200)); end
    mdl_fill(32'h200);
  endtask

  task automatic test_flush();
    int rc, lat; logic [31:0] ra, rd; bit ok;
    do_load(32'h104, 1, 1'b0, rc, ra, rd, lat, ok);
    mdl_fill(32'h104);
    @(negedge clk); flush = 1'b1; #1;
    n_checks++; if (core_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready got=%b exp=0", core_ready); end
    @(negedge clk); flush = 1'b0;
    mdl_clear();
    do_load(32'h104, 2, 1'b0, rc, ra, rd, lat, ok);
    n_checks++; if (!ok || rc != 1 || rd !== 32'h0000_CCDD) begin n_errors++; $display("FAIL flush_miss ok=%0d rd_en=%0d rdata=%h exp 1 0000ccdd", ok, rc, rd); end
    mdl_fill(32'h104);
    do_load(32'h1104, 3, 1'b1, rc, ra, rd, lat, ok);
    n_checks++; if (!ok || rc != 1 || rd !== exp_word(32'h1104)) begin n_errors++; $display("FAIL flush_in_wait ok=%0d rd_en=%0d rdata=%h exp=%h", ok, rc, rd, exp_word(32'h1104)); end
    mdl_fill(32'h1104);
    do_load(32'h1104, 3, 1'b0, rc, ra, rd, lat, ok);
    n_checks++; if (!ok || rc != 0) begin n_errors++; $display("FAIL flush_ignored_hit ok=%0d rd_en=%0d exp=0", ok, rc); end
  endtask

  task automatic test_reset_mid_refill();
    int rc, lat, nrv, nrd; logic [31:0] ra, rd; bit ok, seen;
    seen = 1'b0;
    @(negedge clk); core_req = 1'b1; core_we = 1'b0; core_addr = 32'h104; #1;
    for (int w = 0; w < 20 && !core_ready; w++) begin @(negedge clk); #1; end
    @(negedge clk); core_req = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (mem_rd_en) seen = 1'b1; else @(negedge clk);
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL rstwait_rd_en got=0 exp=1"); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (core_ready !== 1'b0) begin n_errors++; $display("FAIL rstwait_ready got=%b exp=0", core_ready); end
    rst = 1'b1;
    mdl_clear();
    @(negedge clk);
    mem_rd_valid = 1'b1; mem_rd_data = get_line(32'h100);
    nrv = 0; nrd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); mem_rd_valid = 1'b0;
      if (core_rvalid) nrv++;
      if (mem_rd_en) nrd++;
    end
    n_checks++; if (nrv != 0 || nrd != 0) begin n_errors++; $display("FAIL rstwait_stray rvalid=%0d rd_en=%0d exp 0 0", nrv, nrd); end
    do_load(32'h104, 2, 1'b0, rc, ra, rd, lat, ok);
    n_checks++; if (!ok || rc != 1 || rd !== 32'h0000_CCDD) begin n_errors++; $display("FAIL rstwait_reload ok=%0d rd_en=%0d rdata=%h exp 1 0000ccdd", ok, rc, rd); end
    mdl_fill(32'h104);
  endtask

  task automatic test_random();
    bit [31:0] lines [8] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_1100, 32'h0000_2100,
                             32'h0000_0040, 32'h0000_1040, 32'h0000_03F0, 32'h0000_13F0};
    bit [31:0] a, d;
    bit [3:0]  be;
    int sel, rdy, dly, wc, rc, lat;
    logic [31:0] wa, wd, ra, rd;
    logic [3:0] wbe;
    bit ok, exp_miss;
    for (int i = 0; i < 80; i++) begin
      a   = lines[$urandom_range(0, 7)] | (32'($urandom_range(0, 3)) << 2);
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        mdl_clear();
      end else if (sel < 4) begin
        d = $urandom; be = 4'($urandom_range(0, 15)); rdy = int'($urandom_range(0, 3));
        do_store(a, d, be, rdy, wc, wa, wd, wbe, ok);
        n_checks++;
        if (!ok || wc != rdy + 1 || wa !== a || wd !== d || wbe !== be) begin
          n_errors++;
          $display("FAIL rand_store ok=%0d cycles=%0d/%0d addr=%h/%h data=%h/%h be=%b/%b", ok, wc, rdy + 1, wa, a, wd, d, wbe, be);
        end
        mdl_store(a, d, be);
      end else begin
        dly = int'($urandom_range(1, 4));
        exp_miss = !mdl_hit(a);
        do_load(a, dly, 1'b0, rc, ra, rd, lat, ok);
        n_checks++;
        if (!ok || rc != (exp_miss ? 1 : 0) || (exp_miss && ra !== {a[31:4], 4'b0}) || rd !== exp_word(a)) begin
          n_errors++;
          $display("FAIL rand_load addr=%h ok=%0d rd_en=%0d exp_miss=%0d rd_addr=%h rdata=%h exp=%h", a, ok, rc, exp_miss, ra, rd, exp_word(a));
        end
        mdl_fill(a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_miss_hit();
    test_store_partial();
    test_conflict();
    test_store_miss();
    test_flush();
    test_reset_mid_refill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
